// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: opcode values and FSM state encoding.
package alu_share_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_BSUBA = 3'd1,
    OP_ASUBB = 3'd2,
    OP_ADD   = 3'd3,
    OP_XOR   = 3'd4,
    OP_OR    = 3'd5,
    OP_AND   = 3'd6,
    OP_ONES  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesting units (master) and the arbiter (slave).
interface alu_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ready;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_core.sv
// Combinational 8-operation ALU; arithmetic wraps mod 2^W, carry discarded.
module alu_core
  import alu_share_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] F
);

  always_comb begin
    // NOTE: default assignment first so every path drives F and no latch is inferred.
    F = '0;
    case (alu_op_e'(op))
      OP_ZERO:  F = '0;
      OP_BSUBA: F = B - A;
      OP_ASUBB: F = A - B;
      OP_ADD:   F = A + B;
      OP_XOR:   F = A ^ B;
      OP_OR:    F = A | B;
      OP_AND:   F = A & B;
      OP_ONES:  F = '1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU: grant in IDLE, execute in EXEC, hold result in RESP.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic               Clock,
  input  logic               Resetn,
  alu_share_arbiter_if.slave bus,
  output logic               busy
);

  localparam logic [IDW:0]   NREQ_X  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [IDW-1:0] gnt_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_data_q;

  logic [NREQ-1:0] valid_rot;
  logic [IDW-1:0]  rot_sel;
  logic [IDW:0]    gnt_sum;
  logic [IDW-1:0]  gnt_idx;
  logic            any_valid;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic [W-1:0]    alu_f;

  // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
  assign valid_rot = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);

  always_comb begin
    any_valid = |bus.req_valid;
    rot_sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) rot_sel = IDW'(k);
    end
    gnt_sum = {1'b0, rot_sel} + {1'b0, rr_ptr_q};
    if (gnt_sum >= NREQ_X) gnt_sum = gnt_sum - NREQ_X;
    gnt_idx = gnt_sum[IDW-1:0];
  end

  always_comb begin
    state_d = state_q;
    ready   = '0;
    if (state_q == ST_IDLE && Resetn && any_valid) ready = NREQ'(1) << gnt_idx;
    accept = |(ready & bus.req_valid);
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!Resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      // NOTE: operand and result registers are reset too, so a dropped operation leaves no trace.
      rr_ptr_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        op_q     <= 3'(bus.req_op >> (int'(gnt_idx) * 3));
        a_q      <= W'(bus.req_a >> (int'(gnt_idx) * W));
        b_q      <= W'(bus.req_b >> (int'(gnt_idx) * W));
        gnt_q    <= gnt_idx;
        rr_ptr_q <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == ST_EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= alu_f;
        rsp_id_q    <= gnt_q;
      end else if (state_q == ST_RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  alu_core #(.W(W)) u_alu (
    .op (op_q),
    .A  (a_q),
    .B  (b_q),
    .F  (alu_f)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 4-bit, 8-operation ALU between several requesters. Each requester presents an opcode and two operands through a valid/ready handshake. The block grants one request at a time, latches its operands, executes on the shared ALU, and returns a registered result tagged with the requester index through a second valid/ready handshake. It sits between the requesting datapath units and the single ALU instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 4: operand and result width.
- `IDW`, 2: requester index width, equal to ceil(log2(NREQ)).
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Resetn` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: bit i set means requester i has a pending operation.
- `req_op` input 3*NREQ: opcode of requester i in bits [3i+2:3i].
- `req_a` input W*NREQ: operand A of requester i in bits [W*i+W-1:W*i].
- `req_b` input W*NREQ: operand B of requester i, same packing as `req_a`.
- `req_ready` output NREQ: one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid` output 1: a result is available.
- `rsp_id` output IDW: index of the requester that owns the result.
- `rsp_data` output W: the result.
- `rsp_ready` input 1: the consumer accepts the result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Opcodes, with all arithmetic taken mod 2^W and the carry discarded:
  - 0: all zeros
  - 1: B−A
  - 2: A−B
  - 3: A+B
  - 4: A^B
  - 5: A|B
  - 6: A&B
  - 7: all ones
- FSM states: IDLE, EXEC, RESP. State encoding lives in the package.
- IDLE:
  - If any `req_valid` bit is set, grant the first valid index at or after `rr_ptr`, searching upward and wrapping.
  - `req_ready[g]` is driven combinationally high in IDLE only.
  - Handshake completes when `req_valid[g]` and `req_ready[g]` are both high. At that edge: latch op, A, B and g; set `rr_ptr` to (g+1) mod NREQ; go to EXEC.
- EXEC: the shared ALU evaluates the latched operands. At the edge, load `rsp_data` and `rsp_id` from the ALU output and latched g, set `rsp_valid`, and go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id` and `rsp_data` stable until `rsp_ready` is high.
  - On the edge with `rsp_ready` high: clear `rsp_valid` and go to IDLE.
  - No new grant is made in RESP.
- Requesters must hold `req_valid`, `req_op`, `req_a` and `req_b` stable until accepted.
- If `req_valid` drops before acceptance, nothing is latched.
- A requester that does not deassert `req_valid` after acceptance is treated as issuing a new request. It is granted again only when its round-robin turn comes.

## Timing
- Reset values, applied asynchronously while `Resetn` is low:
  - state = IDLE, `rr_ptr` = 0
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0
  - `busy` = 0
  - `req_ready` = 0 while `Resetn` is low
- Latency: request accepted at edge T, EXEC during T..T+1, `rsp_valid` high from edge T+1. The result is visible in the cycle after acceptance plus one, i.e. 2 cycles from the accepting cycle.
- Peak throughput is 1 operation per 3 cycles, when `rsp_ready` is held high.
- Simultaneous requests: exactly one `req_ready` bit is high per cycle. No requester waits more than NREQ−1 grants.
- `rr_ptr` wraps from NREQ−1 to 0.
- Reset asserted in EXEC or RESP: the in-flight operation is dropped and no response is produced. After release, the first grant goes to the lowest-index valid requester.
- `rsp_ready` high while `rsp_valid` is low has no effect.

## Structure
- Shared package holds:
  - opcode constants `OP_ZERO` .. `OP_ONES`, values 0..7
  - state constants `ST_IDLE`, `ST_EXEC`, `ST_RESP`
- One sub-module, `alu_core`: combinational, parameter W, ports op[2:0], A, B and F. It contains the 8-way opcode decode and is instantiated once.
- Round-robin grant logic is inline in the top: rotate by `rr_ptr`, priority-encode, then un-rotate.

## Test plan
- Single request: requester 0, op 3, A=9, B=8, `rsp_ready`=1 → `rsp_valid` high 2 cycles after acceptance, `rsp_data`=4'h1, `rsp_id`=0.
- Subtraction wrap: requester 2, op 1, A=3, B=1 → `rsp_data`=4'hE, `rsp_id`=2. Op 7 returns 4'hF; op 0 returns 4'h0.
- Fairness: all four `req_valid` held high, `rsp_ready`=1 → grant order 0,1,2,3,0,1. A new acceptance occurs every 3 cycles.
- Backpressure: `rsp_ready` low for 5 cycles after `rsp_valid` → data and id held constant, `req_ready`=0, `busy`=1. Release → returns to IDLE next cycle.
- Reset mid-op: `Resetn` pulsed low during EXEC → `rsp_valid`=0 immediately, `busy`=0, `rr_ptr`=0. No stale response appears after release.
- Withdrawn request: `req_valid[1]` pulses one cycle while requester 0 is in RESP → requester 1 is never granted and no response with `rsp_id`=1 is produced.
